// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller bundle: ID/EX hazard inputs and stall/flush controls.
// master = pipeline side, slave = hazard_ctrl_unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_br_taken;
  logic              ex_busy;
  logic              pc_stall;
  logic              if_id_stall;
  logic              id_ex_bubble;
  logic              id_ex_stall;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [1:0]        hz_state;
  logic [CNT_W-1:0]  lu_count;
  logic [CNT_W-1:0]  fl_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, ex_busy,
    input  pc_stall, if_id_stall, id_ex_bubble, id_ex_stall, if_id_flush, id_ex_flush,
    input  hz_state, lu_count, fl_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_br_taken, ex_busy,
    output pc_stall, if_id_stall, id_ex_bubble, id_ex_stall, if_id_flush, id_ex_flush,
    output hz_state, lu_count, fl_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / MDU-freeze hazard controller for the 5-stage pipeline.
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_ctrl_unit_if.slave    hif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LD_STALL = 2'd1;
  localparam logic [2:0] LAT_M1      = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_LAT   = (LOAD_LAT > 1);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       lu_hit_s;
  logic       lu_acc_s;
  logic       fl_acc_s;
  logic       pc_stall_s;
  logic       if_id_stall_s;
  logic       bubble_s;
  logic       id_ex_stall_s;
  logic       flush_s;

  // Load-use match between the EX load and the ID source operands
  always_comb begin
    lu_hit_s = hif.ex_memread && (hif.ex_rd != {REG_AW{1'b0}}) &&
               ((hif.id_use_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                (hif.id_use_rs2 && (hif.id_rs2 == hif.ex_rd)));
  end

  // Control decode and next state; priority busy > branch > load stall
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pc_stall_s    = 1'b0;
    if_id_stall_s = 1'b0;
    bubble_s      = 1'b0;
    id_ex_stall_s = 1'b0;
    flush_s       = 1'b0;
    lu_acc_s      = 1'b0;
    fl_acc_s      = 1'b0;
    if (hif.ex_busy) begin
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      id_ex_stall_s = 1'b1;
    end else if (hif.ex_br_taken) begin
      flush_s     = 1'b1;
      fl_acc_s    = 1'b1;
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = 3'd0;
    end else begin
      case (state_r)
        ST_LD_STALL: begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          bubble_s      = 1'b1;
          cnt_nxt_s     = cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LD_STALL;
          end
        end
        ST_RUN: begin
          if (lu_hit_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            bubble_s      = 1'b1;
            lu_acc_s      = 1'b1;
            if (MULTI_LAT) begin
              state_nxt_s = ST_LD_STALL;
              cnt_nxt_s   = LAT_M1;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  // FSM state and remaining-bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Controls are forced low the instant reset asserts, even mid-stall
  assign hif.pc_stall     = rst_n & pc_stall_s;
  assign hif.if_id_stall  = rst_n & if_id_stall_s;
  assign hif.id_ex_bubble = rst_n & bubble_s;
  assign hif.id_ex_stall  = rst_n & id_ex_stall_s;
  assign hif.if_id_flush  = rst_n & flush_s;
  assign hif.id_ex_flush  = rst_n & flush_s;
  assign hif.hz_state     = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_r;
  logic [CNT_W-1:0] fl_cnt_r;

  // Saturating perf counters; accept strobes are already zero while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_r <= {CNT_W{1'b0}};
      fl_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (lu_acc_s && (lu_cnt_r != {CNT_W{1'b1}})) begin
        lu_cnt_r <= lu_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        lu_cnt_r <= lu_cnt_r;
      end
      if (fl_acc_s && (fl_cnt_r != {CNT_W{1'b1}})) begin
        fl_cnt_r <= fl_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fl_cnt_r <= fl_cnt_r;
      end
    end
  end

  assign hif.lu_count = lu_cnt_r;
  assign hif.fl_count = fl_cnt_r;
`else
  logic unused_acc_s;
  assign unused_acc_s = lu_acc_s ^ fl_acc_s;
  assign hif.lu_count = {CNT_W{1'b0}};
  assign hif.fl_count = {CNT_W{1'b0}};
`endif

endmodule
